// File: rtl/power_monitor_pkg.sv
// ---------------------------------------------------------------------------
// power_monitor_pkg
// Shared types and constants for the power-monitor scan controller.
//   state_t          : scan sequencer states
//   UV_FAULT..OV_FAULT : threshold select codes carried in cfg_addr[1:0]
//   MAX_CONVERTERS   : width of the pgood bus / largest legal rail count
// ---------------------------------------------------------------------------
package power_monitor_pkg;

    localparam int MAX_CONVERTERS = 32;

    localparam logic [1:0] UV_FAULT = 2'd0;
    localparam logic [1:0] UV_WARN  = 2'd1;
    localparam logic [1:0] OV_WARN  = 2'd2;
    localparam logic [1:0] OV_FAULT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        EVAL,
        NEXT
    } state_t;

endpackage

// File: rtl/power_monitor_threshold_cmp.sv
// ---------------------------------------------------------------------------
// power_monitor_threshold_cmp
// Purely combinational window classifier for one ADC sample.
// Ports:
//   sample      in  DATA_WIDTH  captured ADC sample
//   uv_fault    in  DATA_WIDTH  under-voltage fault threshold
//   uv_warn     in  DATA_WIDTH  under-voltage warning threshold
//   ov_warn     in  DATA_WIDTH  over-voltage warning threshold
//   ov_fault    in  DATA_WIDTH  over-voltage fault threshold
//   timeout     in  1           conversion never completed
//   fault_range out 1           sample outside the fault window (or timeout)
//   warn_range  out 1           inside fault window but outside warn window
// Compares are unsigned; a sample equal to a threshold counts as in range.
// ---------------------------------------------------------------------------
module power_monitor_threshold_cmp #(
    parameter int DATA_WIDTH = 12
) (
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] uv_fault,
    input  logic [DATA_WIDTH-1:0] uv_warn,
    input  logic [DATA_WIDTH-1:0] ov_warn,
    input  logic [DATA_WIDTH-1:0] ov_fault,
    input  logic                  timeout,
    output logic                  fault_range,
    output logic                  warn_range
);

    always_comb begin
        fault_range = timeout || (sample < uv_fault) || (sample > ov_fault);
        warn_range  = !fault_range && ((sample < uv_warn) || (sample > ov_warn));
    end

endmodule

// File: rtl/power_monitor_sequencer.sv
// ---------------------------------------------------------------------------
// power_monitor_sequencer
// Round-robin ADC scan controller: selects each rail, waits for the mux to
// settle, fires a start-of-conversion, waits (bounded) for end-of-conversion,
// classifies the sample against four per-rail thresholds and publishes
// pgood/warn/fault status plus an end-of-scan pulse.
// Ports:
//   clock, reset_n  clock (rising edge) and asynchronous active-low reset
//   enable          run continuous scans while high
//   cfg_we/addr/wdata  threshold write port; addr[6:2]=rail, addr[1:0]=select
//   adc_mux_sel     rail currently selected
//   adc_soc         one-cycle start-of-conversion pulse
//   adc_eoc/adc_data  conversion done pulse and its sample
//   fault_clr       clears the sticky fault flag
//   pgood_bus       per-rail power-good (unused upper bits are 0)
//   warn            OR of per-rail warning status (level)
//   fault           sticky fault flag
//   eoc             one-cycle pulse after the last rail of a scan
//   busy            sequencer is not idle
// Build option: POWER_MONITOR_FAULT_FILTER_EN requires three consecutive
// out-of-range samples on a rail before fault/pgood react.
// ---------------------------------------------------------------------------
module power_monitor_sequencer
    import power_monitor_pkg::*;
#(
    parameter int NUM_CONVERTERS = 8,
    parameter int DATA_WIDTH     = 12,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  cfg_we,
    input  logic [6:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic [4:0]            adc_mux_sel,
    output logic                  adc_soc,
    input  logic                  adc_eoc,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  fault_clr,
    output logic [31:0]           pgood_bus,
    output logic                  warn,
    output logic                  fault,
    output logic                  eoc,
    output logic                  busy
);

    localparam int              IDX_W        = (NUM_CONVERTERS > 1) ? $clog2(NUM_CONVERTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CONVERTERS - 1);
    localparam logic [15:0]     SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0]     TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state, next_state;
    logic [15:0]             cnt;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   thr [NUM_CONVERTERS][4];
    logic [DATA_WIDTH-1:0]   snap [4];
    logic [DATA_WIDTH-1:0]   sample_q;
    logic                    timeout_q;
    logic [NUM_CONVERTERS-1:0] pgood_q;
    logic [NUM_CONVERTERS-1:0] warn_q;
    logic                    fault_q;
    logic                    fault_range, warn_range, fault_eff;
    logic                    cfg_hit;
    logic [IDX_W-1:0]        cfg_rail;

    // Writes aimed at rails that do not exist are dropped rather than aliased.
    assign cfg_hit  = cfg_we && (32'(cfg_addr[6:2]) < 32'(NUM_CONVERTERS));
    assign cfg_rail = cfg_addr[2 +: IDX_W];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CONVERTERS; i++)
                for (int j = 0; j < 4; j++)
                    thr[i][j] <= (j >= int'(OV_WARN)) ? {DATA_WIDTH{1'b1}} : '0;
        end else if (cfg_hit) begin
            thr[cfg_rail][cfg_addr[1:0]] <= cfg_wdata;
        end
    end

    // Classification uses the snapshot taken at eoc, so a threshold write
    // landing during the evaluation cannot disturb the current sample.
    power_monitor_threshold_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .sample      (sample_q),
        .uv_fault    (snap[UV_FAULT]),
        .uv_warn     (snap[UV_WARN]),
        .ov_warn     (snap[OV_WARN]),
        .ov_fault    (snap[OV_FAULT]),
        .timeout     (timeout_q),
        .fault_range (fault_range),
        .warn_range  (warn_range)
    );

`ifdef POWER_MONITOR_FAULT_FILTER_EN
    logic [1:0] flt_cnt [NUM_CONVERTERS];

    // Saturating run-length of out-of-range samples per rail; the third
    // consecutive one is the first that is allowed to count as a fault.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CONVERTERS; i++)
                flt_cnt[i] <= 2'd0;
        end else if (state == EVAL) begin
            if (!fault_range)
                flt_cnt[idx] <= 2'd0;
            else if (flt_cnt[idx] != 2'd2)
                flt_cnt[idx] <= flt_cnt[idx] + 2'd1;
        end
    end

    assign fault_eff = fault_range && (flt_cnt[idx] == 2'd2);
`else
    assign fault_eff = fault_range;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (adc_eoc || (cnt == TIMEOUT_LAST)) next_state = EVAL;
            EVAL:    next_state = NEXT;
            NEXT:    next_state = enable ? SETTLE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One counter serves both SETTLE and WAIT; it restarts on every state
    // change, so each state sees it counting from zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sample_q  <= '0;
            timeout_q <= 1'b0;
            pgood_q   <= '0;
            warn_q    <= '0;
            fault_q   <= 1'b0;
            for (int j = 0; j < 4; j++)
                snap[j] <= '0;
        end else begin
            state <= next_state;
            cnt   <= (state != next_state) ? 16'd0 : cnt + 16'd1;
            case (state)
                START: timeout_q <= 1'b0;
                WAIT: begin
                    if (adc_eoc) begin
                        sample_q <= adc_data;
                        for (int j = 0; j < 4; j++)
                            snap[j] <= thr[idx][j];
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout_q <= 1'b1;
                    end
                end
                EVAL: begin
                    pgood_q[idx] <= !fault_eff;
                    warn_q[idx]  <= warn_range;
                end
                NEXT: begin
                    if (!enable || (idx == LAST_IDX))
                        idx <= '0;
                    else
                        idx <= idx + 1'b1;
                end
                default: ;
            endcase
            // A fault raised in the same cycle as fault_clr must survive.
            if ((state == EVAL) && fault_eff)
                fault_q <= 1'b1;
            else if (fault_clr)
                fault_q <= 1'b0;
        end
    end

    always_comb begin
        adc_mux_sel = 5'(idx);
        adc_soc     = (state == START);
        eoc         = (state == NEXT) && (idx == LAST_IDX);
        busy        = (state != IDLE);
        warn        = |warn_q;
        fault       = fault_q;
        pgood_bus   = MAX_CONVERTERS'(pgood_q);
    end

endmodule

// File: tb/tb_power_monitor_sequencer.sv
// ---------------------------------------------------------------------------
// tb_power_monitor_sequencer
// Directed testbench for power_monitor_sequencer with four rails. An ADC
// model answers each start-of-conversion with adc_eoc in the sixth WAIT
// cycle, returning a per-rail value from resp[], or never answers for rails
// flagged in drop_eoc. Build option: POWER_MONITOR_FAULT_FILTER_EN selects
// the filtered-fault scenario instead of the immediate-fault scenarios.
// ---------------------------------------------------------------------------
module tb_power_monitor_sequencer;

    localparam int NUM_CONV = 4;
    localparam int DW       = 12;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          enable    = 1'b0;
    logic          cfg_we    = 1'b0;
    logic [6:0]    cfg_addr  = '0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          adc_eoc   = 1'b0;
    logic [DW-1:0] adc_data  = '0;
    logic          fault_clr = 1'b0;
    logic [4:0]    adc_mux_sel;
    logic          adc_soc;
    logic [31:0]   pgood_bus;
    logic          warn, fault, eoc, busy;

    int            checks    = 0;
    int            errors    = 0;
    int            cyc       = 0;
    int            soc_count = 0;
    int            soc_cycle [NUM_CONV];
    logic [DW-1:0] resp [NUM_CONV];
    logic [NUM_CONV-1:0] drop_eoc = '0;

    power_monitor_sequencer #(
        .NUM_CONVERTERS (NUM_CONV),
        .DATA_WIDTH     (DW),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .adc_mux_sel (adc_mux_sel),
        .adc_soc     (adc_soc),
        .adc_eoc     (adc_eoc),
        .adc_data    (adc_data),
        .fault_clr   (fault_clr),
        .pgood_bus   (pgood_bus),
        .warn        (warn),
        .fault       (fault),
        .eoc         (eoc),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ADC model: soc seen in START, eoc driven during the 6th WAIT cycle.
    always begin : adc_model
        int r;
        @(negedge clock);
        if (adc_soc === 1'b1) begin
            r = int'(adc_mux_sel) % NUM_CONV;
            soc_count++;
            soc_cycle[r] = cyc;
            @(posedge clock);
            repeat (5) @(posedge clock);
            if (!drop_eoc[r]) begin
                #1;
                adc_eoc  = 1'b1;
                adc_data = resp[r];
                @(posedge clock);
                #1;
                adc_eoc  = 1'b0;
                adc_data = '0;
            end
        end
    end

    task automatic wait_eoc(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (eoc === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_soc(input int rail, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (adc_soc === 1'b1 && int'(adc_mux_sel) == rail) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic cfg_write(input int rail, input int sel, input int val);
        @(negedge clock);
        cfg_we    = 1'b1;
        cfg_addr  = 7'(rail * 4 + sel);
        cfg_wdata = DW'(val);
        @(negedge clock);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_fault_clr();
        @(negedge clock);
        fault_clr = 1'b1;
        @(negedge clock);
        fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (pgood_bus !== 32'h0) begin errors++; $display("[TB] FAIL reset_pgood actual=%h expected=%h", pgood_bus, 32'h0); end
        checks++; if (warn !== 1'b0) begin errors++; $display("[TB] FAIL reset_warn actual=%b expected=0", warn); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault actual=%b expected=0", fault); end
        checks++; if (eoc !== 1'b0) begin errors++; $display("[TB] FAIL reset_eoc actual=%b expected=0", eoc); end
        checks++; if (adc_soc !== 1'b0) begin errors++; $display("[TB] FAIL reset_soc actual=%b expected=0", adc_soc); end
        checks++; if (adc_mux_sel !== 5'd0) begin errors++; $display("[TB] FAIL reset_mux actual=%0d expected=0", adc_mux_sel); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy actual=%b expected=0", busy); end
    endtask

    task automatic test_config();
        for (int r = 0; r < NUM_CONV; r++) begin
            cfg_write(r, 0, 100);
            cfg_write(r, 1, 200);
            cfg_write(r, 2, 3000);
            cfg_write(r, 3, 3500);
        end
        // Rail 4 does not exist; this write must not land on rail 0.
        cfg_write(4, 0, 4000);
    endtask

    task automatic test_basic_scan();
        bit ok;
        enable = 1'b1;
        wait_eoc(100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL scan_eoc_timeout actual=no_eoc expected=eoc"); end
        checks++; if (pgood_bus !== 32'hF) begin errors++; $display("[TB] FAIL scan_pgood actual=%h expected=%h", pgood_bus, 32'hF); end
        checks++; if (warn !== 1'b0) begin errors++; $display("[TB] FAIL scan_warn actual=%b expected=0", warn); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL scan_fault actual=%b expected=0", fault); end
        checks++; if (soc_cycle[1] - soc_cycle[0] != 13) begin errors++; $display("[TB] FAIL soc_spacing actual=%0d expected=13", soc_cycle[1] - soc_cycle[0]); end
        @(negedge clock);
        checks++; if (eoc !== 1'b0) begin errors++; $display("[TB] FAIL eoc_width actual=%b expected=0", eoc); end
    endtask

    task automatic test_boundary();
        bit ok;
        resp[0] = 200; resp[1] = 3000; resp[2] = 200; resp[3] = 3000;
        wait_eoc(100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bnd_a_eoc actual=no_eoc expected=eoc"); end
        checks++; if (warn !== 1'b0) begin errors++; $display("[TB] FAIL bnd_a_warn actual=%b expected=0", warn); end
        checks++; if (pgood_bus !== 32'hF) begin errors++; $display("[TB] FAIL bnd_a_pgood actual=%h expected=%h", pgood_bus, 32'hF); end
        resp[0] = 100; resp[1] = 1000; resp[2] = 1000; resp[3] = 3500;
        wait_eoc(100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bnd_b_eoc actual=no_eoc expected=eoc"); end
        checks++; if (warn !== 1'b1) begin errors++; $display("[TB] FAIL bnd_b_warn actual=%b expected=1", warn); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL bnd_b_fault actual=%b expected=0", fault); end
        checks++; if (pgood_bus !== 32'hF) begin errors++; $display("[TB] FAIL bnd_b_pgood actual=%h expected=%h", pgood_bus, 32'hF); end
    endtask

    task automatic test_warn_fault();
        bit ok;
        resp[0] = 1000; resp[1] = 1000; resp[2] = 3200; resp[3] = 1000;
        wait_eoc(100, ok);
        checks++; if (warn !== 1'b1) begin errors++; $display("[TB] FAIL warn_level actual=%b expected=1", warn); end
        checks++; if (pgood_bus !== 32'hF) begin errors++; $display("[TB] FAIL warn_pgood actual=%h expected=%h", pgood_bus, 32'hF); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL warn_fault actual=%b expected=0", fault); end
        resp[2] = 3600;
        wait_eoc(100, ok);
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL ov_fault actual=%b expected=1", fault); end
        checks++; if (pgood_bus !== 32'hB) begin errors++; $display("[TB] FAIL ov_pgood actual=%h expected=%h", pgood_bus, 32'hB); end
        checks++; if (warn !== 1'b0) begin errors++; $display("[TB] FAIL ov_warn actual=%b expected=0", warn); end
        resp[2] = 1000;
        wait_eoc(100, ok);
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky actual=%b expected=1", fault); end
        checks++; if (pgood_bus !== 32'hF) begin errors++; $display("[TB] FAIL recover_pgood actual=%h expected=%h", pgood_bus, 32'hF); end
        pulse_fault_clr();
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_clr actual=%b expected=0", fault); end
    endtask

    task automatic test_timeout();
        bit ok;
        drop_eoc[1] = 1'b1;
        wait_eoc(1300, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL tmo_eoc actual=no_eoc expected=eoc"); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL tmo_fault actual=%b expected=1", fault); end
        checks++; if (pgood_bus !== 32'hD) begin errors++; $display("[TB] FAIL tmo_pgood actual=%h expected=%h", pgood_bus, 32'hD); end
        checks++; if (soc_cycle[2] - soc_cycle[1] != 1031) begin errors++; $display("[TB] FAIL tmo_spacing actual=%0d expected=1031", soc_cycle[2] - soc_cycle[1]); end
        drop_eoc[1] = 1'b0;
        wait_eoc(100, ok);
        checks++; if (pgood_bus !== 32'hF) begin errors++; $display("[TB] FAIL tmo_recover actual=%h expected=%h", pgood_bus, 32'hF); end
        pulse_fault_clr();
    endtask

    task automatic test_enable_drop();
        bit ok;
        int socs;
        resp[1] = 3600;
        wait_soc(1, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL en_soc1 actual=no_soc expected=soc"); end
        @(negedge clock);
        enable = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL en_idle actual=busy expected=idle"); end
        checks++; if (adc_mux_sel !== 5'd0) begin errors++; $display("[TB] FAIL en_mux actual=%0d expected=0", adc_mux_sel); end
        checks++; if (pgood_bus !== 32'hD) begin errors++; $display("[TB] FAIL en_pgood actual=%h expected=%h", pgood_bus, 32'hD); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL en_fault actual=%b expected=1", fault); end
        socs = soc_count;
        repeat (20) @(negedge clock);
        checks++; if (soc_count != socs) begin errors++; $display("[TB] FAIL idle_soc actual=%0d expected=%0d", soc_count, socs); end
        checks++; if (pgood_bus !== 32'hD) begin errors++; $display("[TB] FAIL idle_hold actual=%h expected=%h", pgood_bus, 32'hD); end
        resp[1] = 1000;
        pulse_fault_clr();
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL idle_clr actual=%b expected=0", fault); end
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (adc_soc === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL restart_soc actual=no_soc expected=soc"); end
        checks++; if (adc_mux_sel !== 5'd0) begin errors++; $display("[TB] FAIL restart_mux actual=%0d expected=0", adc_mux_sel); end
    endtask

    task automatic test_fault_clr_collision();
        bit ok;
        wait_soc(2, 100, ok);
        resp[0] = 3600;
        wait_soc(0, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL col_soc actual=no_soc expected=soc"); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL col_pre actual=%b expected=0", fault); end
        repeat (7) @(negedge clock);
        fault_clr = 1'b1;
        @(negedge clock);
        fault_clr = 1'b0;
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL col_fault actual=%b expected=1", fault); end
        checks++; if (pgood_bus[0] !== 1'b0) begin errors++; $display("[TB] FAIL col_pgood0 actual=%b expected=0", pgood_bus[0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_soc(2, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_soc actual=no_soc expected=soc"); end
        reset_n = 1'b0;
        #1;
        checks++; if (adc_soc !== 1'b0) begin errors++; $display("[TB] FAIL rst_soc_drop actual=%b expected=0", adc_soc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy actual=%b expected=0", busy); end
        checks++; if (adc_mux_sel !== 5'd0) begin errors++; $display("[TB] FAIL rst_mux actual=%0d expected=0", adc_mux_sel); end
        checks++; if (pgood_bus !== 32'h0) begin errors++; $display("[TB] FAIL rst_pgood actual=%h expected=%h", pgood_bus, 32'h0); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault actual=%b expected=0", fault); end
        repeat (10) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_filter();
        bit ok;
        logic exp_fault;
        for (int s = 0; s < 6; s++) begin
            resp[0] = (s == 2) ? DW'(1000) : DW'(50);
            wait_eoc(100, ok);
            exp_fault = (s == 5);
            checks++; if (fault !== exp_fault) begin errors++; $display("[TB] FAIL filter_fault scan=%0d actual=%b expected=%b", s, fault, exp_fault); end
            checks++; if (pgood_bus[0] !== !exp_fault) begin errors++; $display("[TB] FAIL filter_pgood scan=%0d actual=%b expected=%b", s, pgood_bus[0], !exp_fault); end
        end
    endtask

    initial begin
        for (int r = 0; r < NUM_CONV; r++) begin
            resp[r] = 1000;
            soc_cycle[r] = 0;
        end
        test_reset();
        test_config();
`ifdef POWER_MONITOR_FAULT_FILTER_EN
        enable = 1'b1;
        test_filter();
`else
        test_basic_scan();
        test_boundary();
        test_warn_fault();
        test_timeout();
        test_enable_drop();
        test_fault_clr_collision();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/power_monitor_sequencer.md
Name: power_monitor_sequencer

Overview:
- Hardware scan controller for the power-monitor datapath. Round-robin steps the ADC mux across NUM_CONVERTERS rails and handshakes each conversion.
- Compares each sample against four per-rail thresholds and builds the pgood/warn/fault/eoc outputs in hardware instead of CPU-written control registers.
- Sits between the ADC front end and the power-monitor output bus.

Parameters:
- NUM_CONVERTERS, 8, rails scanned; legal 1..32.
- DATA_WIDTH, 12, ADC sample and threshold width.
- SETTLE_CYCLES, 4, mux settle delay before start-of-conversion; legal 1..255.
- TIMEOUT_CYCLES, 1024, maximum wait for adc_eoc; legal 2..65535.

Ports:
- clock  in  1  single block clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; run continuous scans while high.
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  7  [6:2] rail index; [1:0] threshold select: 0=uv_fault, 1=uv_warn, 2=ov_warn, 3=ov_fault.
- cfg_wdata  in  DATA_WIDTH  threshold value.
- adc_mux_sel  out  5  rail currently selected.
- adc_soc  out  1  one-cycle start-of-conversion pulse.
- adc_eoc  in  1  one-cycle conversion-done pulse.
- adc_data  in  DATA_WIDTH  sample; valid when adc_eoc=1.
- fault_clr  in  1  clears sticky fault state.
- pgood_bus  out  32  per-rail power-good; bits >= NUM_CONVERTERS tied 0.
- warn  out  1  OR of per-rail warn status; level, not sticky.
- fault  out  1  sticky fault.
- eoc  out  1  one-cycle pulse per completed full scan.
- busy  out  1  state != IDLE.

Behaviour:
Reset values:
- All outputs 0; index 0; state IDLE.
- Thresholds reset to uv_*=0 and ov_*=all ones.

State machine (IDLE, SETTLE, START, WAIT, EVAL, NEXT):
- IDLE -> SETTLE when enable=1. adc_mux_sel holds the index.
- SETTLE: counts SETTLE_CYCLES cycles, then -> START.
- START: adc_soc=1 for exactly 1 cycle, then -> WAIT. Timeout counter cleared.
- WAIT:
  - adc_eoc=1 captures adc_data and a snapshot of the rail's 4 thresholds, then -> EVAL.
  - Counter reaching TIMEOUT_CYCLES sets a timeout flag, then -> EVAL.
  - adc_eoc in any other state is ignored.
- EVAL, 1 cycle, per-rail classification:
  - fault_range = timeout OR s < uv_fault OR s > ov_fault.
  - warn_range = !fault_range AND (s < uv_warn OR s > ov_warn).
  - pgood[i] = !fault_range.
  - Compares are unsigned and inclusive-good (s == threshold counts as in range).
- NEXT, 1 cycle:
  - pgood_bus, warn and fault reflect the EVAL result in this cycle (registered, 1 cycle after EVAL).
  - If index == NUM_CONVERTERS-1: eoc=1 and index wraps to 0; else index+1.
  - Then -> SETTLE if enable=1, else -> IDLE with index reset to 0.

Enable handling:
- enable falling mid-scan does not abort: the current conversion completes, then the block goes to IDLE at NEXT.
- pgood_bus holds its last values while idle.

Fault and config rules:
- fault sets on any rail's fault_range and holds until fault_clr.
- fault_clr in the same cycle as a new fault: the new fault wins, fault stays 1.
- A cfg write is visible from the next WAIT snapshot. A write in the same cycle as the snapshot is not used for that sample.
- Writes with rail index >= NUM_CONVERTERS are ignored.

Reset mid-operation:
- Immediate return to reset values; adc_soc drops in the same cycle.

Optional Feature:
- Macro POWER_MONITOR_FAULT_FILTER_EN.
- Defined: per-rail 2-bit counter. fault_range must occur on 3 consecutive samples of that rail before fault/pgood react; any in-range sample clears the counter. warn is unfiltered.
- Undefined: a single out-of-range sample acts immediately. No counters are instantiated.

Decomposition:
- Package power_monitor_pkg:
  - state enum.
  - threshold-select constants (UV_FAULT=0, UV_WARN=1, OV_WARN=2, OV_FAULT=3).
  - MAX_CONVERTERS=32.
- Sub-module power_monitor_threshold_cmp: purely combinational; inputs sample + 4 thresholds + timeout; outputs fault_range and warn_range. Instantiated once.

Test Plan:
- NUM_CONVERTERS=4, thresholds 100/200/3000/3500 on all rails; ADC model returns 1000 after 5 cycles.
  - pgood_bus=0x0000000F after first eoc.
  - adc_soc spacing = SETTLE+START+WAIT+EVAL+NEXT = 4+1+6+1+1 = 13 cycles.
  - warn=0, fault=0.
- Rail 2 returns 3200 -> warn=1, pgood_bus=0xF. Rail 2 then returns 3600 -> fault=1, pgood_bus=0xB. fault stays 1 after rail 2 recovers until fault_clr is pulsed.
- ADC model never asserts adc_eoc on rail 1 -> after 1024 WAIT cycles: fault=1, pgood[1]=0. Scan continues to rail 2.
- enable dropped during WAIT of rail 1 -> adc_eoc still consumed, then IDLE with busy=0. Re-enable restarts at adc_mux_sel=0.
- fault_clr asserted in the same cycle a new fault sets -> fault=1. Assert reset_n=0 during WAIT -> all outputs 0 asynchronously.
- With POWER_MONITOR_FAULT_FILTER_EN: rail 0 returns 50, 50, 1000 -> no fault. Rail 0 returns 50, 50, 50 -> fault=1 in the NEXT cycle of the third sample.
